fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//   Front-end sequencer that owns the program counter and drives a req/gnt/rvalid
//   instruction-memory port. Arbitrates next-PC sources: trap > branch > stall > +4.
//   Tracks one outstanding fetch, discards stale responses after redirects and
//   presents {valid, pc, inst} to the IF/ID register. Sits between hazard unit, EX
//   branch resolution, trap logic and IMEM.
// PARAMETERS
//   RESET_PC   32'h0000_0000   first fetch address after reset
//   NOP_INST   32'h0000_0013   instruction driven on if_inst when nothing valid
// PORTS
//   clk          in   1   clock, all state updates on posedge
//   rst          in   1   synchronous reset, active-low
//   trap_ctrl    in   1   trap/exception redirect request (highest priority)
//   trap_addr    in   32  trap target
//   br_ctrl      in   1   taken branch/jump redirect from EX
//   br_addr      in   32  branch target
//   pc_stall     in   1   hazard unit: hold IF/ID outputs, no new fetch
//   imem_req     out  1   fetch request
//   imem_addr    out  32  fetch address, word aligned
//   imem_gnt     in   1   IMEM accepted request this cycle (req & gnt = handshake)
//   imem_rvalid  in   1   response valid for the single outstanding request
//   imem_rdata   in   32  fetched instruction
//   if_valid     out  1   if_pc/if_inst valid for IF/ID
//   if_pc        out  32  address of if_inst
//   if_inst      out  32  instruction to decode
//   flush_o      out  1   one-cycle pulse: kill IF/ID contents
// BEHAVIOUR
//   Reset (rst==0 at posedge): state=S_IDLE, pc=RESET_PC, drop=0, imem_req=0,
//     imem_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=NOP_INST, flush_o=0.
//   States: S_IDLE -> S_REQ unconditionally (one cycle after reset release).
//     S_REQ: imem_req=1, imem_addr=pc. req&gnt -> S_WAIT, latch req_pc=pc.
//     S_WAIT: imem_req=0. rvalid&!drop -> deliver (below); rvalid&drop -> drop=0,
//       S_REQ with pc unchanged (already holds redirect target).
//     S_HOLD: one-entry buffer full; pc_stall==0 -> present buffer, S_REQ.
//   Deliver: pc_stall==0 -> if_valid<=1, if_pc<=req_pc, if_inst<=rdata, pc<=req_pc+4,
//     S_REQ (next req one cycle after rvalid). pc_stall==1 -> capture into buffer,
//     S_HOLD; if_* unchanged. if_* registered: rvalid at N -> if_valid at N+1.
//   pc_stall with no delivery: if_* hold values; S_REQ keeps requesting same pc.
//   if_valid drops to 0 on any cycle after a non-stalled consume with no new delivery.
//   Redirect (trap_ctrl|br_ctrl, any state except S_IDLE): target = trap wins if both;
//     pc<=target&~3, flush_o<=1 next cycle only, if_valid<=0, buffer cleared.
//     S_REQ without gnt -> stay S_REQ, imem_addr takes new pc next cycle.
//     S_REQ with gnt same cycle, or S_WAIT -> S_WAIT, drop<=1 (stale response eaten).
//     S_WAIT with rvalid same cycle -> response discarded, S_REQ to target.
//     S_HOLD -> S_REQ. Redirect overrides pc_stall.
//   imem_addr stable while req&!gnt except on redirect. pc+4 wraps modulo 2^32.
//   Low two bits of all targets forced to 0. rvalid outside S_WAIT ignored.
//   Reset mid-fetch: state/drop cleared; in-flight response arrives outside S_WAIT
//     and is ignored.
// STRUCTURE
//   fetch_defs.vh: state encodings (S_IDLE,S_REQ,S_WAIT,S_HOLD, 2-bit), NOP_INST,
//     XLEN=32. Shared with IF/ID register and hazard unit.
//   Sub-module fetch_hold_buf: one-entry {pc,inst} buffer, load/clear/valid.
//   Remaining FSM, pc register and priority mux inline; ~200 lines total.
// TESTING
//   1 Reset release, gnt=1, rvalid one cycle after gnt, rdata=0x00500093 -> addrs
//     0,4,8 issued; if_pc=0 with if_inst=0x00500093 one cycle after first rvalid.
//   2 gnt held 0 for 3 cycles at pc=0x10 -> imem_req=1, imem_addr=0x10 stable.
//   3 br_ctrl=1, br_addr=0x203 while in S_WAIT -> flush_o one pulse, next rvalid
//     dropped (if_valid=0), next request at 0x200.
//   4 trap_ctrl & br_ctrl same cycle, trap_addr=0x80 -> fetch 0x80, br ignored.
//   5 pc_stall=1 when rvalid for 0x24 -> if_* unchanged, no req; stall released ->
//     if_pc=0x24, then request 0x28.
//   6 rst=0 with request outstanding, stray rvalid after -> ignored, first fetch RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch FSM states, widths, default NOP and target alignment
package fetch_ctrl_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_ctrl_hold_buf.sv
// fetch_ctrl_hold_buf: one-entry {pc,inst} buffer; ports load_i/clear_i/pc_i/inst_i in, valid_o/pc_o/inst_o out; clear wins over load
module fetch_ctrl_hold_buf
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o
);
    logic            valid_q;
    logic [XLEN-1:0] pc_q, inst_q;
    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            inst_q  <= inst_i;
        end
    end
    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and req/gnt/rvalid IMEM sequencer; redirects (trap>branch) in, imem_req/imem_addr out, {if_valid,if_pc,if_inst} and flush_o to IF/ID
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_ctrl,
    input  logic [XLEN-1:0] trap_addr,
    input  logic            br_ctrl,
    input  logic [XLEN-1:0] br_addr,
    input  logic            pc_stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    output logic            flush_o
);
    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d, if_pc_q, if_pc_d, if_inst_q, if_inst_d;
    logic            drop_q, drop_d, if_valid_q, if_valid_d, flush_q, flush_d;
    logic            redirect, buf_load, buf_clear, buf_valid;
    logic [XLEN-1:0] target, buf_pc, buf_inst;

    assign redirect = (trap_ctrl | br_ctrl) && state_q != S_IDLE;
    assign target   = word_align(trap_ctrl ? trap_addr : br_addr);

    fetch_ctrl_hold_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .pc_i    (req_pc_q),
        .inst_i  (imem_rdata),
        .valid_o (buf_valid),
        .pc_o    (buf_pc),
        .inst_o  (buf_inst)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        if_valid_d = pc_stall & if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        flush_d    = redirect;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    // pc already holds the redirect target when a stale response is eaten
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (pc_stall) begin
                        buf_load = 1'b1;
                        state_d  = S_HOLD;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_inst_d  = imem_rdata;
                        pc_d       = req_pc_q + 32'd4;
                        state_d    = S_REQ;
                    end
                end
            end
            default: begin
                if (!pc_stall && buf_valid) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = buf_pc;
                    if_inst_d  = buf_inst;
                    pc_d       = buf_pc + 32'd4;
                    buf_clear  = 1'b1;
                    state_d    = S_REQ;
                end
            end
        endcase
        // A request already accepted (or still in flight) must have its response dropped
        if (redirect) begin
            pc_d       = target;
            if_valid_d = 1'b0;
            buf_load   = 1'b0;
            buf_clear  = 1'b1;
            state_d    = ((state_q == S_REQ && imem_gnt) || (state_q == S_WAIT && !imem_rvalid)) ? S_WAIT : S_REQ;
            drop_d     = state_d == S_WAIT;
        end
        if (!if_valid_d) if_inst_d = NOP_INST;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            drop_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= NOP_INST;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            flush_q    <= flush_d;
        end
    end

    assign imem_req  = state_q == S_REQ;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;
    assign flush_o   = flush_q;
endmodule
